key_event_decoder: RTL

Classifies debounced key activity into discrete user commands for the pulse generator control path. Sits directly downstream of the key debounce filter: it consumes the filter's one-cycle `key_flag` strobe and its `key_state` level, and emits one-cycle command pulses (short, double, long, auto-repeat). The parameter-update logic consumes these pulses to step pulse period and duty.

---
 rtl/key_pkg.sv | 30 +++
 rtl/key_event_decoder_if.sv | 21 ++
 rtl/key_event_decoder.sv | 110 +++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types for the key event decoder: FSM state encoding, the command
// pulse bundle, and the event code used by downstream pulse encoders.
package key_pkg;

  // One-hot decoder states.
  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_PRESS1    = 5'b00010,
    ST_WAIT2     = 5'b00100,
    ST_PRESS2    = 5'b01000,
    ST_LONG_HOLD = 5'b10000
  } state_e;

  // Compact command code for consumers that encode the pulses.
  typedef enum logic [1:0] {
    EV_SHORT  = 2'd0,
    EV_DOUBLE = 2'd1,
    EV_LONG   = 2'd2,
    EV_REPEAT = 2'd3
  } event_e;

  // The four mutually exclusive command pulses.
  typedef struct packed {
    logic repeat_p;
    logic long_p;
    logic double_p;
    logic short_p;
  } pulse_t;

endpackage

// File: rtl/key_event_decoder_if.sv
// Key event bus: debounce-filter strobe/level in, command pulses out.
// master = the side driving key activity, slave = the decoder.
interface key_event_decoder_if;
  logic key_flag;
  logic key_state;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_held;

  modport master (
    output key_flag, key_state,
    input  short_pulse, double_pulse, long_pulse, repeat_pulse, key_held
  );

  modport slave (
    input  key_flag, key_state,
    output short_pulse, double_pulse, long_pulse, repeat_pulse, key_held
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies debounced key edges into short / double / long / auto-repeat
// command pulses. One counter is shared by all states since only one timeout
// is ever live; it clears on every state change and on each repeat tick.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT    = 100_000_000,
  parameter int unsigned DBL_GAP_CNT = 15_000_000,
  parameter int unsigned REPEAT_CNT  = 10_000_000,
  parameter bit          DBL_EN      = 1'b1,
  parameter int unsigned CNT_W       = 27
) (
  input logic           clk,
  input logic           reset,
  key_event_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  pulse_t           pulse_nxt, pulse_q;
  logic             held_nxt, held_q;
  logic             key_press, key_release;

  assign key_press   = bus.key_flag & ~bus.key_state;
  assign key_release = bus.key_flag &  bus.key_state;

  // Next-state, next-pulse and counter-clear decode.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    pulse_nxt = '0;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_press) state_nxt = ST_PRESS1;
      end
      ST_PRESS1: begin
        // Release beats the long threshold when both land together.
        if (key_release) begin
          if (DBL_EN) begin
            state_nxt = ST_WAIT2;
          end else begin
            pulse_nxt.short_p = 1'b1;
            state_nxt         = ST_IDLE;
          end
        end else if (cnt == LONG_LAST) begin
          pulse_nxt.long_p = 1'b1;
          state_nxt        = ST_LONG_HOLD;
        end
      end
      ST_WAIT2: begin
        // A press on the timeout cycle still makes a double click.
        if (key_press) begin
          state_nxt = ST_PRESS2;
        end else if (cnt == GAP_LAST) begin
          pulse_nxt.short_p = 1'b1;
          state_nxt         = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (key_release) begin
          pulse_nxt.double_p = 1'b1;
          state_nxt          = ST_IDLE;
        end
      end
      ST_LONG_HOLD: begin
        // Release suppresses a coincident repeat tick.
        if (key_release) begin
          state_nxt = ST_IDLE;
        end else if (cnt == REP_LAST) begin
          pulse_nxt.repeat_p = 1'b1;
          cnt_clr            = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state) cnt_clr = 1'b1;
    held_nxt = (state_nxt == ST_PRESS1) || (state_nxt == ST_PRESS2) ||
               (state_nxt == ST_LONG_HOLD);
  end

  // State, shared counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pulse_q <= '0;
      held_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_clr ? '0 : cnt + 1'b1;
      pulse_q <= pulse_nxt;
      held_q  <= held_nxt;
    end
  end

  assign bus.short_pulse  = pulse_q.short_p;
  assign bus.double_pulse = pulse_q.double_p;
  assign bus.long_pulse   = pulse_q.long_p;
  assign bus.repeat_pulse = pulse_q.repeat_p;
  assign bus.key_held     = held_q;

endmodule
